// File: rtl/pid_controller_v2.sv
// Multicycle fixed-point PID controller: one sample per 5 cycles, 4-cycle latency.
// Define PID_DERIVATIVE_EN to include the derivative term and its e_prev history.
//
// state | meaning
// IDLE  | waiting for a sample; in_ready high when enabled
// ERR   | error e = setpoint - in_data
// MUL   | P, integrator increment and D products
// SUM   | clamped integrator candidate and full-width sum
// OUT   | saturate, publish result, commit integrator / e_prev
module pid_controller_v2 #(
    parameter int inputBitSize    = 27,
    parameter int inputFracSize   = 25,
    parameter int outputBitSize   = 16,
    parameter int outputFracSize  = 15,
    parameter int coeffBitSize    = 27,
    parameter int coeffFracSize   = 26,
    parameter int productFracSize = 27
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            clear_pid,
    input  logic                            enable_pid,
    input  logic                            hold_integral,
    input  logic signed [inputBitSize-1:0]  setpoint,
    input  logic signed [inputBitSize-1:0]  in_data,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic signed [coeffBitSize-1:0]  kp,
    input  logic signed [coeffBitSize-1:0]  ki,
    input  logic signed [coeffBitSize-1:0]  kd,
    output logic signed [outputBitSize-1:0] pid_output,
    output logic                            out_valid,
    output logic                            out_saturated
);
    localparam int EW    = inputBitSize + 1;
    localparam int SHIFT = coeffFracSize + inputFracSize - productFracSize;
    localparam int MW    = coeffBitSize + EW;
    localparam int PW    = MW - SHIFT;
    localparam int OSH   = productFracSize - outputFracSize;
    localparam int IW    = outputBitSize + OSH;
    localparam int SW    = (outputBitSize - outputFracSize) + (PW - productFracSize) + 3 + productFracSize;
    localparam int SHW   = SW - OSH;

    localparam logic signed [IW-1:0] I_MAX = {1'b0, {(outputBitSize-1){1'b1}}, {OSH{1'b0}}};
    localparam logic signed [IW-1:0] I_MIN = {1'b1, {(IW-1){1'b0}}};
    localparam logic signed [outputBitSize-1:0] O_MAX = {1'b0, {(outputBitSize-1){1'b1}}};
    localparam logic signed [outputBitSize-1:0] O_MIN = {1'b1, {(outputBitSize-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_ERR, S_MUL, S_SUM, S_OUT} state_t;

    state_t                           state_q, state_d;
    logic signed [inputBitSize-1:0]   sp_q, sp_d, din_q, din_d;
    logic signed [coeffBitSize-1:0]   kp_q, kp_d, ki_q, ki_d;
    logic signed [EW-1:0]             e_q, e_d;
    logic signed [PW-1:0]             p_q, p_d, iinc_q, iinc_d;
    logic signed [PW:0]               d_q, d_d;
    logic signed [IW-1:0]             icand_q, icand_d, integ_q, integ_d;
    logic signed [SW-1:0]             sum_q, sum_d;
    logic signed [outputBitSize-1:0]  pid_output_q, pid_output_d;
    logic                             out_valid_q, out_valid_d, out_sat_q, out_sat_d;

    logic signed [MW-1:0]             p_full, i_full;
    logic signed [PW:0]               icand_w;
    logic signed [SHW-1:0]            sum_sh;
    logic                             sat_hi, sat_lo, iinc_pos, iinc_neg, accept;
    logic                             unused_bits;

    assign p_full = $signed({{(MW-coeffBitSize){kp_q[coeffBitSize-1]}}, kp_q})
                  * $signed({{(MW-EW){e_q[EW-1]}}, e_q});
    assign i_full = $signed({{(MW-coeffBitSize){ki_q[coeffBitSize-1]}}, ki_q})
                  * $signed({{(MW-EW){e_q[EW-1]}}, e_q});
    assign icand_w = $signed({{(PW+1-IW){integ_q[IW-1]}}, integ_q}) + $signed({iinc_q[PW-1], iinc_q});
    assign sum_sh   = sum_q[SW-1:OSH];
    assign sat_hi   = sum_sh > $signed({{(SHW-outputBitSize){1'b0}}, O_MAX});
    assign sat_lo   = sum_sh < $signed({{(SHW-outputBitSize){1'b1}}, O_MIN});
    assign iinc_pos = !iinc_q[PW-1] && (iinc_q != '0);
    assign iinc_neg = iinc_q[PW-1];
    assign in_ready = (state_q == S_IDLE) && enable_pid && !reset;
    assign accept   = in_valid && in_ready;

`ifdef PID_DERIVATIVE_EN
    localparam int DMW = MW + 1;
    logic signed [coeffBitSize-1:0] kd_q, kd_d;
    logic signed [EW-1:0]           e_prev_q, e_prev_d;
    logic                           first_q, first_d;
    logic signed [EW:0]             de;
    logic signed [DMW-1:0]          d_full;

    // First sample after reset/clear uses its own error as history: no derivative kick.
    assign de     = {e_q[EW-1], e_q} - (first_q ? {e_q[EW-1], e_q} : {e_prev_q[EW-1], e_prev_q});
    assign d_full = $signed({{(DMW-coeffBitSize){kd_q[coeffBitSize-1]}}, kd_q})
                  * $signed({{(DMW-EW-1){de[EW]}}, de});
    assign unused_bits = ^{p_full[SHIFT-1:0], i_full[SHIFT-1:0], d_full[SHIFT-1:0], sum_q[OSH-1:0]};
`else
    assign unused_bits = ^{p_full[SHIFT-1:0], i_full[SHIFT-1:0], sum_q[OSH-1:0], kd};
`endif

    always_comb begin
        state_d      = state_q;
        sp_d         = sp_q;
        din_d        = din_q;
        kp_d         = kp_q;
        ki_d         = ki_q;
        e_d          = e_q;
        p_d          = p_q;
        iinc_d       = iinc_q;
        d_d          = d_q;
        icand_d      = icand_q;
        sum_d        = sum_q;
        integ_d      = integ_q;
        pid_output_d = pid_output_q;
        out_valid_d  = 1'b0;
        out_sat_d    = out_sat_q;
`ifdef PID_DERIVATIVE_EN
        kd_d         = kd_q;
        e_prev_d     = e_prev_q;
        first_d      = first_q;
`endif
        if (state_q != S_IDLE && !enable_pid) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: if (accept) begin
                    sp_d    = setpoint;
                    din_d   = in_data;
                    kp_d    = kp;
                    ki_d    = ki;
`ifdef PID_DERIVATIVE_EN
                    kd_d    = kd;
`endif
                    state_d = S_ERR;
                end
                S_ERR: begin
                    e_d     = {sp_q[inputBitSize-1], sp_q} - {din_q[inputBitSize-1], din_q};
                    state_d = S_MUL;
                end
                S_MUL: begin
                    p_d     = p_full[SHIFT +: PW];
                    iinc_d  = i_full[SHIFT +: PW];
`ifdef PID_DERIVATIVE_EN
                    d_d     = d_full[SHIFT +: PW+1];
`else
                    d_d     = '0;
`endif
                    state_d = S_SUM;
                end
                S_SUM: begin
                    if (icand_w > $signed({{(PW+1-IW){1'b0}}, I_MAX}))      icand_d = I_MAX;
                    else if (icand_w < $signed({{(PW+1-IW){1'b1}}, I_MIN})) icand_d = I_MIN;
                    else                                                   icand_d = icand_w[IW-1:0];
                    sum_d   = $signed({{(SW-PW){p_q[PW-1]}}, p_q})
                            + $signed({{(SW-IW){icand_d[IW-1]}}, icand_d})
                            + $signed({{(SW-PW-1){d_q[PW]}}, d_q});
                    state_d = S_OUT;
                end
                S_OUT: begin
                    pid_output_d = sat_hi ? O_MAX : (sat_lo ? O_MIN : sum_sh[outputBitSize-1:0]);
                    out_valid_d  = 1'b1;
                    out_sat_d    = sat_hi || sat_lo;
                    // Conditional anti-windup: stop integrating further into the rail.
                    if (!(hold_integral || (sat_hi && iinc_pos) || (sat_lo && iinc_neg)))
                        integ_d = icand_q;
`ifdef PID_DERIVATIVE_EN
                    e_prev_d     = e_q;
                    first_d      = 1'b0;
`endif
                    state_d      = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear_pid) begin
            state_q      <= S_IDLE;
            sp_q         <= '0;
            din_q        <= '0;
            kp_q         <= '0;
            ki_q         <= '0;
            e_q          <= '0;
            p_q          <= '0;
            iinc_q       <= '0;
            d_q          <= '0;
            icand_q      <= '0;
            sum_q        <= '0;
            integ_q      <= '0;
            pid_output_q <= '0;
            out_valid_q  <= 1'b0;
            out_sat_q    <= 1'b0;
`ifdef PID_DERIVATIVE_EN
            kd_q         <= '0;
            e_prev_q     <= '0;
            first_q      <= 1'b1;
`endif
        end else begin
            state_q      <= state_d;
            sp_q         <= sp_d;
            din_q        <= din_d;
            kp_q         <= kp_d;
            ki_q         <= ki_d;
            e_q          <= e_d;
            p_q          <= p_d;
            iinc_q       <= iinc_d;
            d_q          <= d_d;
            icand_q      <= icand_d;
            sum_q        <= sum_d;
            integ_q      <= integ_d;
            pid_output_q <= pid_output_d;
            out_valid_q  <= out_valid_d;
            out_sat_q    <= out_sat_d;
`ifdef PID_DERIVATIVE_EN
            kd_q         <= kd_d;
            e_prev_q     <= e_prev_d;
            first_q      <= first_d;
`endif
        end
    end

    assign pid_output    = pid_output_q;
    assign out_valid     = out_valid_q;
    assign out_saturated = out_sat_q;
endmodule

// File: tb/tb_pid_controller_v2.sv
// Directed bench for pid_controller_v2; expectations follow PID_DERIVATIVE_EN when defined.
module tb_pid_controller_v2;
    localparam logic signed [26:0] X0   = 27'sh0000000;
    localparam logic signed [26:0] X05  = 27'sh1000000;
    localparam logic signed [26:0] X15  = 27'sh3000000;
    localparam logic signed [26:0] K05  = 27'sh2000000;
    localparam logic signed [26:0] K025 = 27'sh1000000;
    localparam logic signed [26:0] K0125 = 27'sh0800000;

    logic clk = 1'b0, reset = 1'b1, clear_pid = 1'b0, enable_pid = 1'b1, hold_integral = 1'b0;
    logic signed [26:0] setpoint = '0, in_data = '0, kp = '0, ki = '0, kd = '0;
    logic in_valid = 1'b0, in_ready, out_valid, out_saturated;
    logic signed [15:0] pid_output;
    int n_checks = 0, n_pass = 0;

    pid_controller_v2 dut (
        .clk(clk), .reset(reset), .clear_pid(clear_pid), .enable_pid(enable_pid),
        .hold_integral(hold_integral), .setpoint(setpoint), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready), .kp(kp), .ki(ki), .kd(kd),
        .pid_output(pid_output), .out_valid(out_valid), .out_saturated(out_saturated)
    );

    always #5 clk = ~clk;

    // Drives one sample and watches 8 cycles; returns result, saturation, latency and pulse count.
    task automatic run_sample(input logic signed [26:0] sp, din, gp, gi, gd,
                              output logic [15:0] res, output logic sat,
                              output int lat, output int pulses);
        @(negedge clk);
        setpoint = sp; in_data = din; kp = gp; ki = gi; kd = gd; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0; pulses = 0; res = 16'hxxxx; sat = 1'bx;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                pulses++;
                if (lat == 0) begin lat = i; res = pid_output; sat = out_saturated; end
            end
        end
    endtask

    task automatic pulse_clear();
        @(negedge clk); clear_pid = 1'b1;
        @(negedge clk); clear_pid = 1'b0;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b expected 0", in_ready); else n_pass++;
        n_checks++;
        if ({pid_output, out_valid, out_saturated} !== 18'h0)
            $display("FAIL reset_outputs: got out=%h v=%b s=%b expected 0 0 0", pid_output, out_valid, out_saturated);
        else n_pass++;
        @(negedge clk); reset = 1'b0;
        #1;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL idle_in_ready: got %b expected 1", in_ready); else n_pass++;
    endtask

    task automatic test_proportional();
        logic [15:0] r; logic s; int lat, np;
        pulse_clear();
        run_sample(X05, X0, K05, X0, X0, r, s, lat, np);
        n_checks++; if (r !== 16'h2000 || s !== 1'b0) $display("FAIL p_pos: got %h sat %b expected 2000 sat 0", r, s); else n_pass++;
        n_checks++; if (lat != 4) $display("FAIL p_latency: got %0d expected 4", lat); else n_pass++;
        n_checks++; if (np != 1) $display("FAIL p_pulses: got %0d expected 1", np); else n_pass++;
        n_checks++; if (pid_output !== 16'h2000) $display("FAIL p_hold: got %h expected 2000", pid_output); else n_pass++;
        run_sample(X0, X05, K05, X0, X0, r, s, lat, np);
        n_checks++; if (r !== 16'hE000) $display("FAIL p_neg: got %h expected e000", r); else n_pass++;
    endtask

    task automatic test_integral();
        logic [15:0] r; logic s; int lat, np;
        logic [15:0] exp_i [4] = '{16'h1000, 16'h2000, 16'h3000, 16'h4000};
        pulse_clear();
        for (int k = 0; k < 4; k++) begin
            run_sample(X05, X0, X0, K025, X0, r, s, lat, np);
            n_checks++; if (r !== exp_i[k]) $display("FAIL integ_%0d: got %h expected %h", k, r, exp_i[k]); else n_pass++;
        end
        pulse_clear();
        hold_integral = 1'b1;
        for (int k = 0; k < 2; k++) begin
            run_sample(X05, X0, X0, K025, X0, r, s, lat, np);
            n_checks++; if (r !== 16'h1000) $display("FAIL hold_%0d: got %h expected 1000", k, r); else n_pass++;
        end
        hold_integral = 1'b0;
    endtask

    task automatic test_antiwindup();
        logic [15:0] r; logic s; int lat, np;
        logic [15:0] exp_o [3] = '{16'h7800, 16'h7FFF, 16'h7FFF};
        logic        exp_s [3] = '{1'b0, 1'b1, 1'b1};
        pulse_clear();
        for (int k = 0; k < 3; k++) begin
            run_sample(X15, X0, K0125, K05, X0, r, s, lat, np);
            n_checks++;
            if (r !== exp_o[k] || s !== exp_s[k])
                $display("FAIL windup_%0d: got %h sat %b expected %h sat %b", k, r, s, exp_o[k], exp_s[k]);
            else n_pass++;
        end
        run_sample(X0, X05, K0125, K05, X0, r, s, lat, np);
        n_checks++; if (r !== 16'h3800 || s !== 1'b0) $display("FAIL unwind: got %h sat %b expected 3800 sat 0", r, s); else n_pass++;
    endtask

    task automatic test_derivative();
        logic [15:0] r; logic s; int lat, np;
        logic [15:0] exp_d [3];
        logic signed [26:0] sp_seq [3] = '{X0, X05, X05};
`ifdef PID_DERIVATIVE_EN
        exp_d = '{16'h0000, 16'h2000, 16'h0000};
`else
        exp_d = '{16'h0000, 16'h0000, 16'h0000};
`endif
        pulse_clear();
        run_sample(X05, X0, X0, X0, K05, r, s, lat, np);
        n_checks++; if (r !== 16'h0000) $display("FAIL d_no_kick: got %h expected 0000", r); else n_pass++;
        pulse_clear();
        for (int k = 0; k < 3; k++) begin
            run_sample(sp_seq[k], X0, X0, X0, K05, r, s, lat, np);
            n_checks++; if (r !== exp_d[k]) $display("FAIL deriv_%0d: got %h expected %h", k, r, exp_d[k]); else n_pass++;
        end
    endtask

    task automatic test_clear_mid();
        logic [15:0] r; logic s; int lat, np, seen;
        pulse_clear();
        run_sample(X05, X0, X0, K025, X0, r, s, lat, np);
        @(negedge clk); setpoint = X05; in_data = X0; ki = K025; in_valid = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk); clear_pid = 1'b1;
        @(negedge clk); clear_pid = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin @(posedge clk); #1; if (out_valid) seen++; end
        n_checks++; if (seen != 0) $display("FAIL clear_abort: got %0d pulses expected 0", seen); else n_pass++;
        n_checks++; if (pid_output !== 16'h0000) $display("FAIL clear_output: got %h expected 0000", pid_output); else n_pass++;
        @(negedge clk); in_valid = 1'b1; clear_pid = 1'b1;
        @(negedge clk); in_valid = 1'b0; clear_pid = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin @(posedge clk); #1; if (out_valid) seen++; end
        n_checks++; if (seen != 0) $display("FAIL clear_accept: got %0d pulses expected 0", seen); else n_pass++;
        run_sample(X05, X0, X0, K025, X0, r, s, lat, np);
        n_checks++; if (r !== 16'h1000) $display("FAIL clear_integ: got %h expected 1000", r); else n_pass++;
    endtask

    task automatic test_busy();
        int bad, pulses;
        pulse_clear();
        @(negedge clk); setpoint = X05; in_data = X0; kp = K05; ki = X0; kd = X0; in_valid = 1'b1;
        bad = 0; pulses = 0;
        for (int i = 0; i <= 4; i++) begin
            @(posedge clk); #1;
            if (i < 4 && in_ready !== 1'b0) bad++;
            if (out_valid) pulses++;
        end
        in_valid = 1'b0;
        n_checks++; if (bad != 0) $display("FAIL busy_ready: got %0d high cycles expected 0", bad); else n_pass++;
        n_checks++; if (pulses != 1 || pid_output !== 16'h2000) $display("FAIL busy_single: got %0d pulses out %h expected 1 out 2000", pulses, pid_output); else n_pass++;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin @(posedge clk); #1; if (out_valid) pulses++; end
        n_checks++; if (pulses != 0) $display("FAIL busy_second: got %0d pulses expected 0", pulses); else n_pass++;
    endtask

    task automatic test_enable_drop();
        logic [15:0] r; logic s; int lat, np, seen;
        pulse_clear();
        run_sample(X05, X0, X0, K025, X0, r, s, lat, np);
        @(negedge clk); in_valid = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk); enable_pid = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin @(posedge clk); #1; if (out_valid) seen++; end
        n_checks++; if (seen != 0 || in_ready !== 1'b0) $display("FAIL enable_abort: got %0d pulses ready %b expected 0 0", seen, in_ready); else n_pass++;
        @(negedge clk); enable_pid = 1'b1;
        run_sample(X05, X0, X0, K025, X0, r, s, lat, np);
        n_checks++; if (r !== 16'h2000) $display("FAIL enable_integ: got %h expected 2000", r); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_proportional();
        test_integral();
        test_antiwindup();
        test_derivative();
        test_clear_mid();
        test_busy();
        test_enable_drop();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
